// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC datapath stages.
package mac_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam int PROD_W_DEF = 16;
  localparam int ACC_W_DEF  = 24;
  localparam int LEN_W_DEF  = 8;

  // Saturation bounds of a w-bit two's complement value (w <= 63).
  function automatic logic signed [63:0] acc_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] acc_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/sat_add.sv
// W-bit signed add that clamps to the representable range and flags the clamp.
module sat_add
  import mac_pkg::*;
#(
  parameter int W = ACC_W_DEF
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum,
  output logic                ovf
);

  localparam logic signed [63:0] MAX = acc_max(W);
  localparam logic signed [63:0] MIN = acc_min(W);

  logic signed [W:0]  wide;
  logic signed [63:0] wide64;

  always_comb begin
    wide   = {a[W-1], a} + {b[W-1], b};
    wide64 = 64'(wide);
    sum    = wide[W-1:0];
    ovf    = 1'b0;
    if (wide64 > MAX) begin
      sum = MAX[W-1:0];
      ovf = 1'b1;
    end else if (wide64 < MIN) begin
      sum = MIN[W-1:0];
      ovf = 1'b1;
    end
  end

endmodule

// File: rtl/mac_dot_accumulator.sv
// Accumulates a programmable number of MAC products into a saturating dot
// product and hands it downstream on a valid/ready handshake.
module mac_dot_accumulator
  import mac_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    prod_valid,
  input  logic signed [PROD_W-1:0] prod_in,
  output logic                    prod_ready,
  input  logic [LEN_W-1:0]        vec_len,
  output logic                    busy,
  output logic                    acc_valid,
  input  logic                    acc_ready,
  output logic signed [ACC_W-1:0] acc_out,
  output logic                    acc_ovf
);

  state_t             state;
  logic [LEN_W:0]     count;
  logic [LEN_W-1:0]   len_q;
  logic signed [ACC_W-1:0] prod_x;
  logic signed [ACC_W-1:0] sum;
  logic               sum_ovf;

  assign prod_x = ACC_W'(prod_in);

  sat_add #(.W(ACC_W)) u_sat_add (
    .a   (acc_out),
    .b   (prod_x),
    .sum (sum),
    .ovf (sum_ovf)
  );

  // Output flags are registered alongside state so no input reaches an output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc_out    <= '0;
      acc_ovf    <= 1'b0;
      acc_valid  <= 1'b0;
      busy       <= 1'b0;
      prod_ready <= 1'b1;
      count      <= '0;
      len_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (prod_valid) begin
            len_q   <= (vec_len == '0) ? LEN_W'(1) : vec_len;
            acc_out <= prod_x;
            acc_ovf <= 1'b0;
            count   <= (LEN_W+1)'(1);
            busy    <= 1'b1;
            if (vec_len <= LEN_W'(1)) begin
              state      <= HOLD;
              acc_valid  <= 1'b1;
              prod_ready <= 1'b0;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (prod_valid) begin
            acc_out <= sum;
            acc_ovf <= acc_ovf | sum_ovf;
            count   <= count + 1'b1;
            if (count + 1'b1 == {1'b0, len_q}) begin
              state      <= HOLD;
              acc_valid  <= 1'b1;
              prod_ready <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (acc_ready) begin
            state      <= IDLE;
            acc_valid  <= 1'b0;
            prod_ready <= 1'b1;
            busy       <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          acc_valid  <= 1'b0;
          prod_ready <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_dot_accumulator.sv
// Drives two widths of the accumulator in lockstep and compares them against
// a vector-level reference model built from queued products.
module tb_mac_dot_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        prod_valid;
  logic [15:0] prod_in;
  logic [7:0]  vec_len;
  logic        acc_ready;

  logic        pr18, busy18, av18, ovf18;
  logic [17:0] acc18;
  logic        pr24, busy24, av24, ovf24;
  logic [23:0] acc24;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  longint vec_q[$];
  int     tgt;
  bit     in_vec, holding;
  longint e_acc18, e_acc24;
  bit     e_ovf18, e_ovf24;

  always #5 clk = ~clk;

  mac_dot_accumulator #(.PROD_W(16), .ACC_W(18), .LEN_W(8)) dut18 (
    .clk(clk), .rst(rst), .prod_valid(prod_valid), .prod_in(prod_in),
    .prod_ready(pr18), .vec_len(vec_len), .busy(busy18), .acc_valid(av18),
    .acc_ready(acc_ready), .acc_out(acc18), .acc_ovf(ovf18)
  );

  mac_dot_accumulator #(.PROD_W(16), .ACC_W(24), .LEN_W(8)) dut24 (
    .clk(clk), .rst(rst), .prod_valid(prod_valid), .prod_in(prod_in),
    .prod_ready(pr24), .vec_len(vec_len), .busy(busy24), .acc_valid(av24),
    .acc_ready(acc_ready), .acc_out(acc24), .acc_ovf(ovf24)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Running sum with a clamp after every add, as an ACC_W-bit register would.
  function automatic void calc(input int w, output longint r, output bit o);
    longint mx = (longint'(1) <<< (w - 1)) - 1;
    longint mn = -mx - 1;
    r = 0;
    o = 1'b0;
    foreach (vec_q[i]) begin
      r += vec_q[i];
      if (r > mx) begin r = mx; o = 1'b1; end
      else if (r < mn) begin r = mn; o = 1'b1; end
    end
  endfunction

  task automatic step(input bit r, input bit pv, input logic [15:0] p,
                      input logic [7:0] vl, input bit ar);
    rst = r; prod_valid = pv; prod_in = p; vec_len = vl; acc_ready = ar;
    @(posedge clk);
    #1;
    if (r) begin
      in_vec = 0; holding = 0; vec_q.delete();
      e_acc18 = 0; e_acc24 = 0; e_ovf18 = 0; e_ovf24 = 0;
    end else if (holding) begin
      if (ar) holding = 0;
    end else if (pv) begin
      if (!in_vec) begin
        vec_q.delete();
        tgt = (vl == 0) ? 1 : int'(vl);
        in_vec = 1;
      end
      vec_q.push_back(longint'($signed(p)));
      if (vec_q.size() == tgt) begin
        in_vec = 0;
        holding = 1;
        calc(18, e_acc18, e_ovf18);
        calc(24, e_acc24, e_ovf24);
      end
    end
    chk("prod_ready18", pr18, !holding);
    chk("prod_ready24", pr24, !holding);
    chk("busy18", busy18, in_vec || holding);
    chk("busy24", busy24, in_vec || holding);
    chk("acc_valid18", av18, holding);
    chk("acc_valid24", av24, holding);
    if (!in_vec) begin
      chk("acc_out18", longint'($signed(acc18)), e_acc18);
      chk("acc_out24", longint'($signed(acc24)), e_acc24);
      chk("acc_ovf18", ovf18, e_ovf18);
      chk("acc_ovf24", ovf24, e_ovf24);
    end
  endtask

  task automatic send(input logic [15:0] p, input logic [7:0] vl);
    step(0, 1, p, vl, 0);
  endtask

  task automatic idle(input bit ar);
    step(0, 0, 16'h0, 8'd0, ar);
  endtask

  initial begin
    in_vec = 0; holding = 0;
    // reset state
    step(1, 1, 16'h1234, 8'd3, 1);
    chk("rst_acc", longint'(acc24), 0);
    idle(0);

    // single product
    send(16'h0406, 8'd1);
    chk("single", longint'($signed(acc24)), 1030);
    idle(1);
    idle(0);

    // four-product dot product, widely spaced
    send(16'd1030, 8'd4);
    repeat (7) idle(0);
    send(16'hFE0C, 8'd9);
    repeat (7) idle(0);
    send(16'd200, 8'd9);
    repeat (7) idle(0);
    send(16'd7, 8'd9);
    chk("dot", longint'($signed(acc24)), 737);
    idle(1);

    // positive and negative saturation, then a clean vector
    repeat (5) send(16'h7FFF, 8'd5);
    chk("sat_pos18", longint'($signed(acc18)), 131071);
    chk("sat_pos_ovf18", ovf18, 1);
    idle(1);
    send(16'd5, 8'd1);
    chk("after_sat_ovf18", ovf18, 0);
    idle(1);
    repeat (5) send(16'h8000, 8'd5);
    chk("sat_neg18", longint'($signed(acc18)), -131072);
    idle(1);

    // backpressure: pulses during hold are dropped, including at the handoff
    send(16'd11, 8'd2);
    send(16'd22, 8'd2);
    repeat (3) step(0, 1, 16'd99, 8'd1, 0);
    step(0, 1, 16'd99, 8'd1, 1);
    send(16'd40, 8'd1);
    chk("bp_new_vec", longint'($signed(acc24)), 40);
    idle(1);

    // reset mid-vector, then a fresh short vector
    send(16'd100, 8'd4);
    send(16'd100, 8'd4);
    step(1, 0, 16'd0, 8'd0, 0);
    chk("mid_rst_busy", busy24, 0);
    send(16'd3, 8'd2);
    send(16'd4, 8'd2);
    chk("post_rst", longint'($signed(acc24)), 7);
    idle(1);

    // edge lengths
    send(16'd9, 8'd0);
    chk("len0", longint'($signed(acc24)), 9);
    idle(1);
    repeat (254) send(16'd1, 8'd255);
    chk("len255_early", av24, 0);
    send(16'd1, 8'd255);
    chk("len255", longint'($signed(acc24)), 255);
    idle(1);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      logic [15:0] p;
      case ($urandom_range(0, 3))
        0: p = 16'h7FFF;
        1: p = 16'h8000;
        default: p = 16'($urandom);
      endcase
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) != 0), p,
           8'($urandom_range(0, 7)), ($urandom_range(0, 1) == 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
